// File: rtl/branch_fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: the resolved-branch
// inputs from decode, the instruction-memory port, and the IF/ID register
// outputs with the redirect/illegal event pulses.
//   slave  : used by branch_fetch_stage (drives imem_addr_o, id_*, pulses)
//   master : used by the surrounding core / testbench
// Handshake: there is no valid/ready pair here; br_valid_i qualifies the
// br_* operand bus in the cycle it is high, stall_i holds the stage, and the
// *_o pulses are single-cycle registered events.
interface branch_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            br_valid_i;
  logic [2:0]      br_funct3_i;
  logic [XLEN-1:0] br_rs1_i;
  logic [XLEN-1:0] br_rs2_i;
  logic [XLEN-1:0] br_pc_i;
  logic [XLEN-1:0] br_imm_i;
  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     imem_data_i;
  logic            id_valid_o;
  logic [31:0]     id_inst_o;
  logic [XLEN-1:0] id_pc_o;
  logic            redirect_o;
  logic            illegal_br_o;

  modport slave (
    input  stall_i, br_valid_i, br_funct3_i, br_rs1_i, br_rs2_i, br_pc_i,
           br_imm_i, imem_data_i,
    output imem_addr_o, id_valid_o, id_inst_o, id_pc_o, redirect_o,
           illegal_br_o
  );

  modport master (
    output stall_i, br_valid_i, br_funct3_i, br_rs1_i, br_rs2_i, br_pc_i,
           br_imm_i, imem_data_i,
    input  imem_addr_o, id_valid_o, id_inst_o, id_pc_o, redirect_o,
           illegal_br_o
  );
endinterface

// File: rtl/branch_fetch_stage.sv
// Fetch stage: PC register, RV32I conditional-branch resolution and the
// IF/ID pipeline register with stall and post-redirect bubble insertion.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         branch_fetch_stage_if.slave (branch inputs, imem port, IF/ID)
//   dbg_state_o current FSM state (0 = RUN, 1 = FLUSH) for observation
module branch_fetch_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_fetch_stage_if.slave  bus,
  output logic                 dbg_state_o
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_FLUSH = 1'b1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]  CNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [0:0]  ST_AFTER_BR = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [0:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            redirect_q, redirect_d;
  logic            illegal_q, illegal_d;

  logic            cond;
  logic            f3_legal;
  logic [XLEN-1:0] target;
  logic            aligned;
  logic [XLEN-1:0] pc_inc;
  logic            br_taken;
  logic            br_illegal;

  // Branch condition evaluation; funct3 010/011 are not branches.
  always_comb begin
    cond     = 1'b0;
    f3_legal = 1'b1;
    case (bus.br_funct3_i)
      3'b000:  cond = (bus.br_rs1_i == bus.br_rs2_i);
      3'b001:  cond = (bus.br_rs1_i != bus.br_rs2_i);
      3'b100:  cond = ($signed(bus.br_rs1_i) <  $signed(bus.br_rs2_i));
      3'b101:  cond = ($signed(bus.br_rs1_i) >= $signed(bus.br_rs2_i));
      3'b110:  cond = (bus.br_rs1_i <  bus.br_rs2_i);
      3'b111:  cond = (bus.br_rs1_i >= bus.br_rs2_i);
      default: f3_legal = 1'b0;
    endcase
  end

  // Carry out of the target add is dropped; the PC space wraps.
  assign target  = bus.br_pc_i + bus.br_imm_i;
  assign aligned = (target[1:0] == 2'b00);
  assign pc_inc  = pc_q + XLEN'(4);

  // Branches are only resolved in RUN; in FLUSH decode holds wrong-path work.
  assign br_taken   = (state_q == ST_RUN) && bus.br_valid_i && cond && aligned;
  assign br_illegal = (state_q == ST_RUN) && bus.br_valid_i &&
                      (!f3_legal || (cond && !aligned));

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    redirect_d = 1'b0;
    illegal_d  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          // A taken branch wins over stall so the redirect is never lost.
          pc_d       = target;
          id_valid_d = 1'b0;
          id_inst_d  = NOP;
          redirect_d = 1'b1;
          cnt_d      = CNT_INIT;
          state_d    = ST_AFTER_BR;
        end else begin
          illegal_d = br_illegal;
          if (!bus.stall_i) begin
            pc_d       = pc_inc;
            id_valid_d = 1'b1;
            id_inst_d  = bus.imem_data_i;
            id_pc_d    = pc_q;
          end
        end
      end
      ST_FLUSH: begin
        if (!bus.stall_i) begin
          pc_d       = pc_inc;
          id_valid_d = 1'b0;
          id_inst_d  = bus.imem_data_i;
          id_pc_d    = pc_q;
          cnt_d      = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP;
      id_pc_q    <= '0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.imem_addr_o  = pc_q;
  assign bus.id_valid_o   = id_valid_q;
  assign bus.id_inst_o    = id_inst_q;
  assign bus.id_pc_o      = id_pc_q;
  assign bus.redirect_o   = redirect_q;
  assign bus.illegal_br_o = illegal_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_branch_fetch_stage.sv
module tb_branch_fetch_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmp_en = 1'b0;
  logic st0, st1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  branch_fetch_stage_if #(.XLEN(32)) bf0 ();
  branch_fetch_stage_if #(.XLEN(32)) bf1 ();

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign bf0.imem_data_i = inst_at(bf0.imem_addr_o);
  assign bf1.imem_data_i = inst_at(bf1.imem_addr_o);

  branch_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bf0), .dbg_state_o(st0));
  branch_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF0), .FLUSH_CYCLES(3))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bf1), .dbg_state_o(st1));

  // ---------------- behavioural model (one entry per instance) -------------
  logic [31:0] m_pc[2], m_inst[2], m_idpc[2];
  logic        m_valid[2], m_redir[2], m_ill[2];
  int          m_bub[2];
  logic [31:0] rst_pc[2];
  int          fcyc[2];
  initial begin
    rst_pc[0] = 32'h0000_0000; fcyc[0] = 1;
    rst_pc[1] = 32'hFFFF_FFF0; fcyc[1] = 3;
  end

  task automatic model_reset(input int k);
    m_pc[k] = rst_pc[k]; m_valid[k] = 1'b0; m_inst[k] = 32'h13;
    m_idpc[k] = '0; m_redir[k] = 1'b0; m_ill[k] = 1'b0; m_bub[k] = 0;
  endtask

  task automatic model_step(input int k, input logic stall, bv,
                            input logic [2:0] f3,
                            input logic [31:0] a, b, bpc, imm);
    logic [31:0] tgt;
    logic cond, legal;
    m_redir[k] = 1'b0;
    m_ill[k]   = 1'b0;
    if (m_bub[k] > 0) begin
      // wrong-path cycles: fetch keeps streaming but nothing is valid
      if (!stall) begin
        m_valid[k] = 1'b0; m_inst[k] = inst_at(m_pc[k]); m_idpc[k] = m_pc[k];
        m_pc[k] = m_pc[k] + 32'd4; m_bub[k] = m_bub[k] - 1;
      end
    end else begin
      legal = (f3 != 3'd2) && (f3 != 3'd3);
      case (f3)
        3'd0: cond = (a == b);
        3'd1: cond = (a != b);
        3'd4: cond = ($signed(a) <  $signed(b));
        3'd5: cond = ($signed(a) >= $signed(b));
        3'd6: cond = (a <  b);
        3'd7: cond = (a >= b);
        default: cond = 1'b0;
      endcase
      tgt = bpc + imm;
      if (bv && legal && cond && (tgt[1:0] == 2'b00)) begin
        m_pc[k] = tgt; m_valid[k] = 1'b0; m_inst[k] = 32'h13;
        m_redir[k] = 1'b1; m_bub[k] = fcyc[k] - 1;
      end else begin
        m_ill[k] = bv && (!legal || (cond && (tgt[1:0] != 2'b00)));
        if (!stall) begin
          m_valid[k] = 1'b1; m_inst[k] = inst_at(m_pc[k]); m_idpc[k] = m_pc[k];
          m_pc[k] = m_pc[k] + 32'd4;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, bf0.stall_i, bf0.br_valid_i, bf0.br_funct3_i, bf0.br_rs1_i,
                 bf0.br_rs2_i, bf0.br_pc_i, bf0.br_imm_i);
      model_step(1, bf1.stall_i, bf1.br_valid_i, bf1.br_funct3_i, bf1.br_rs1_i,
                 bf1.br_rs2_i, bf1.br_pc_i, bf1.br_imm_i);
    end
  end

  // ---------------- scoreboard ------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic valid, input logic [31:0] inst,
                          input logic [31:0] idpc, addr, input logic redir, ill, st);
    check($sformatf("u%0d_addr", k), addr, m_pc[k]);
    check($sformatf("u%0d_valid", k), 32'(valid), 32'(m_valid[k]));
    check($sformatf("u%0d_inst", k), inst, m_inst[k]);
    if (m_valid[k]) check($sformatf("u%0d_idpc", k), idpc, m_idpc[k]);
    check($sformatf("u%0d_redirect", k), 32'(redir), 32'(m_redir[k]));
    check($sformatf("u%0d_illegal", k), 32'(ill), 32'(m_ill[k]));
    check($sformatf("u%0d_state", k), 32'(st), 32'(m_bub[k] > 0));
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      cmp_inst(0, bf0.id_valid_o, bf0.id_inst_o, bf0.id_pc_o, bf0.imem_addr_o,
               bf0.redirect_o, bf0.illegal_br_o, st0);
      cmp_inst(1, bf1.id_valid_o, bf1.id_inst_o, bf1.id_pc_o, bf1.imem_addr_o,
               bf1.redirect_o, bf1.illegal_br_o, st1);
    end
  end

  // ---------------- driver ------------------------------------------------
  // Drives instance k for one cycle; the other instance is held stalled.
  task automatic tick(input int k, input logic st, bv, input logic [2:0] f3,
                      input logic [31:0] a, b, p, im);
    bf0.stall_i = 1'b1; bf0.br_valid_i = 1'b0; bf0.br_funct3_i = 3'd0;
    bf0.br_rs1_i = '0; bf0.br_rs2_i = '0; bf0.br_pc_i = '0; bf0.br_imm_i = '0;
    bf1.stall_i = 1'b1; bf1.br_valid_i = 1'b0; bf1.br_funct3_i = 3'd0;
    bf1.br_rs1_i = '0; bf1.br_rs2_i = '0; bf1.br_pc_i = '0; bf1.br_imm_i = '0;
    if (k == 0) begin
      bf0.stall_i = st; bf0.br_valid_i = bv; bf0.br_funct3_i = f3;
      bf0.br_rs1_i = a; bf0.br_rs2_i = b; bf0.br_pc_i = p; bf0.br_imm_i = im;
    end else begin
      bf1.stall_i = st; bf1.br_valid_i = bv; bf1.br_funct3_i = f3;
      bf1.br_rs1_i = a; bf1.br_rs2_i = b; bf1.br_pc_i = p; bf1.br_imm_i = im;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    tick(k, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    tick(0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0);  // sets idle inputs, reset still low
    @(posedge clk); #1;
    check("rst_addr0", bf0.imem_addr_o, 32'h0);
    check("rst_valid0", 32'(bf0.id_valid_o), 32'd0);
    check("rst_inst0", bf0.id_inst_o, 32'h13);
    check("rst_addr1", bf1.imem_addr_o, 32'hFFFF_FFF0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      idle(0);
      check("seq_idpc", bf0.id_pc_o, 32'(i * 4));
      check("seq_valid", 32'(bf0.id_valid_o), 32'd1);
    end
    // BNE taken 5 != 3, pc 0x10 imm -8
    tick(0, 1'b0, 1'b1, 3'b001, 32'd5, 32'd3, 32'h10, 32'hFFFF_FFF8);
    check("bne_addr", bf0.imem_addr_o, 32'h8);
    check("bne_redir", 32'(bf0.redirect_o), 32'd1);
    check("bne_bubble", 32'(bf0.id_valid_o), 32'd0);
    idle(0);
    check("bne_after_redir", 32'(bf0.redirect_o), 32'd0);
    check("bne_after_idpc", bf0.id_pc_o, 32'h8);
    // BNE not taken
    tick(0, 1'b0, 1'b1, 3'b001, 32'd7, 32'd7, 32'hC, 32'hFFFF_FFF8);
    check("bne_nt_addr", bf0.imem_addr_o, 32'h10);
    // BLT signed -1 < 1 taken
    tick(0, 1'b0, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h20);
    check("blt_addr", bf0.imem_addr_o, 32'h30);
    // BLTU 0xFFFFFFFF < 1 false
    tick(0, 1'b0, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h30, 32'h20);
    check("bltu_addr", bf0.imem_addr_o, 32'h34);
    // BGEU taken
    tick(0, 1'b0, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h34, 32'h100);
    check("bgeu_addr", bf0.imem_addr_o, 32'h134);
    // illegal funct3
    tick(0, 1'b0, 1'b1, 3'b010, 32'd1, 32'd1, 32'h0, 32'h0);
    check("f3_ill", 32'(bf0.illegal_br_o), 32'd1);
    check("f3_noredir", 32'(bf0.redirect_o), 32'd0);
    // misaligned target 0x102
    tick(0, 1'b0, 1'b1, 3'b000, 32'd3, 32'd3, 32'h100, 32'h2);
    check("mis_ill", 32'(bf0.illegal_br_o), 32'd1);
    check("mis_addr", bf0.imem_addr_o, 32'h13C);
    idle(0);
    check("ill_pulse_end", 32'(bf0.illegal_br_o), 32'd0);
    // taken branch with stall: redirect still happens
    tick(0, 1'b1, 1'b1, 3'b000, 32'd4, 32'd4, 32'h200, 32'h40);
    check("stall_br_addr", bf0.imem_addr_o, 32'h240);
    check("stall_br_redir", 32'(bf0.redirect_o), 32'd1);
    tick(0, 1'b1, 1'b0, 3'b000, 0, 0, 0, 0);
    check("stall_hold", bf0.imem_addr_o, 32'h240);
    // BGE signed 1 >= -1 taken; BEQ not taken
    tick(0, 1'b0, 1'b1, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h240, 32'h10);
    check("bge_addr", bf0.imem_addr_o, 32'h250);
    tick(0, 1'b0, 1'b1, 3'b000, 32'd1, 32'd2, 32'h250, 32'h10);
    check("beq_nt_addr", bf0.imem_addr_o, 32'h254);

    // FLUSH_CYCLES=3 instance: wrap then branch
    for (int i = 0; i < 4; i++) idle(1);
    check("wrap_addr", bf1.imem_addr_o, 32'h0);
    check("wrap_idpc", bf1.id_pc_o, 32'hFFFF_FFFC);
    tick(1, 1'b0, 1'b1, 3'b000, 32'd1, 32'd1, 32'h0, 32'h80);
    check("f3_addr", bf1.imem_addr_o, 32'h80);
    check("f3_state", 32'(st1), 32'd1);
    tick(1, 1'b0, 1'b1, 3'b000, 32'd1, 32'd1, 32'h84, 32'h400);
    check("f3_ignored", bf1.imem_addr_o, 32'h84);
    check("f3_noredir", 32'(bf1.redirect_o), 32'd0);
    tick(1, 1'b1, 1'b0, 3'b000, 0, 0, 0, 0);
    check("f3_stall", bf1.imem_addr_o, 32'h84);
    idle(1);
    check("f3_bub3", 32'(bf1.id_valid_o), 32'd0);
    idle(1);
    check("f3_valid", 32'(bf1.id_valid_o), 32'd1);
    check("f3_idpc", bf1.id_pc_o, 32'h88);

    // reset mid-run
    idle(0);
    idle(0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", bf0.imem_addr_o, 32'h0);
    check("mid_rst_valid", 32'(bf0.id_valid_o), 32'd0);
    check("mid_rst_inst", bf0.id_inst_o, 32'h13);
    check("mid_rst_addr1", bf1.imem_addr_o, 32'hFFFF_FFF0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(0);
    check("post_rst_idpc", bf0.id_pc_o, 32'h0);
    idle(0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
